// File: rtl/i2s_sample_sender_pkg.sv
// Shared audio definitions: I2S frame geometry, fetch-FSM states and a saturating counter helper.
package i2s_sample_sender_pkg;

    localparam int SLOTS_PER_FRAME = 32;
    localparam int SAMPLE_WIDTH    = 16;
    localparam int SLOT_WIDTH      = $clog2(SLOTS_PER_FRAME);
    localparam int FRAME_WIDTH     = 2 * SAMPLE_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        POP_L,
        POP_R,
        CAP_R
    } fetch_state_e;

    function automatic logic [SAMPLE_WIDTH-1:0] sat_inc(input logic [SAMPLE_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_sample_sender_clock_gen.sv
// Free-running bclk divider plus the frame slot counter; fall_strobe marks the clock that drives bclk 1->0.
module i2s_clock_gen
    import i2s_sample_sender_pkg::*;
#(
    parameter int CLOCK_DIVIDER = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  bclk,
    output logic                  fall_strobe,
    output logic [SLOT_WIDTH-1:0] slot
);

    localparam int                   DIV_WIDTH = $clog2(CLOCK_DIVIDER);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST  = DIV_WIDTH'(CLOCK_DIVIDER - 1);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 div_wrap;

    assign div_wrap    = (div_cnt == DIV_LAST);
    assign fall_strobe = div_wrap & bclk;

    // Slot resets to the last slot so the first falling bclk edge opens slot 0; wrap is free at 32 slots.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            slot    <= SLOT_WIDTH'(SLOTS_PER_FRAME - 1);
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap)
                bclk <= ~bclk;
            if (fall_strobe)
                slot <= slot + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_sample_sender.sv
// I2S transmitter: fetches one left/right pair per frame from an upstream queue and shifts it out.
// Build option I2S_HOLD_LAST_ON_UNDERRUN_EN: on underrun resend the previous pair instead of silence.
module i2s_sample_sender
    import i2s_sample_sender_pkg::*;
#(
    parameter  int CLOCK_DIVIDER = 4,
    parameter  int QUEUE_SIZE    = 16,
    localparam int SIZE_WIDTH    = $clog2(QUEUE_SIZE)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SIZE_WIDTH-1:0]   queue_size,
    output logic                    dequeue,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun,
    output logic [SAMPLE_WIDTH-1:0] underrun_count
);

    logic                   fall_strobe;
    logic [SLOT_WIDTH-1:0]  slot;
    logic [SLOT_WIDTH-1:0]  slot_next;
    logic                   frame_start_q;
    fetch_state_e           state, state_next;
    logic [FRAME_WIDTH-1:0] pair_q;
    logic [FRAME_WIDTH-1:0] shift_q;

    i2s_clock_gen #(
        .CLOCK_DIVIDER(CLOCK_DIVIDER)
    ) u_clock_gen (
        .clock      (clock),
        .reset      (reset),
        .bclk       (bclk),
        .fall_strobe(fall_strobe),
        .slot       (slot)
    );

    assign slot_next = slot + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_start_q <= 1'b0;
            state         <= IDLE;
        end else begin
            frame_start_q <= fall_strobe && (slot_next == '0);
            state         <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        dequeue    = 1'b0;
        underrun   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start_q) begin
                    if (queue_size > SIZE_WIDTH'(1))
                        state_next = POP_L;
                    else
                        underrun = 1'b1;
                end
            end
            POP_L: begin
                dequeue    = 1'b1;
                state_next = POP_R;
            end
            POP_R: begin
                dequeue    = 1'b1;
                state_next = CAP_R;
            end
            CAP_R:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The queue latch lags dequeue by one cycle: left is visible during POP_R, right during CAP_R.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pair_q <= '0;
        end else if (state == POP_R) begin
            pair_q[FRAME_WIDTH-1:SAMPLE_WIDTH] <= sample_in;
        end else if (state == CAP_R) begin
            pair_q[SAMPLE_WIDTH-1:0] <= sample_in;
`ifdef I2S_HOLD_LAST_ON_UNDERRUN_EN
        end else if (underrun) begin
            pair_q <= pair_q;
`else
        end else if (underrun) begin
            pair_q <= '0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            underrun_count <= '0;
        end else if (underrun) begin
            underrun_count <= sat_inc(underrun_count);
        end
    end

    // One-bit I2S delay: the pair is loaded as slot 1 opens, so the right LSB lands in the next slot 0.
    // NOTE: the shifter and pair are plain registers, not a memory, so they take the async reset too.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lrclk   <= 1'b1;
            sdata   <= 1'b0;
            shift_q <= '0;
        end else if (fall_strobe) begin
            lrclk <= slot_next[SLOT_WIDTH-1];
            if (slot_next == SLOT_WIDTH'(1)) begin
                sdata   <= pair_q[FRAME_WIDTH-1];
                shift_q <= {pair_q[FRAME_WIDTH-2:0], 1'b0};
            end else begin
                sdata   <= shift_q[FRAME_WIDTH-1];
                shift_q <= {shift_q[FRAME_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_sender.sv
// Scoreboard bench for i2s_sample_sender: a queue model feeds the DUT, a bclk-edge monitor checks frames.
module tb_i2s_sample_sender;
    import i2s_sample_sender_pkg::*;

    localparam int CD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  queue_size = '0;
    logic [15:0] sample_in = '0;
    logic        dequeue, bclk, lrclk, sdata, underrun;
    logic [15:0] underrun_count;

    i2s_sample_sender #(
        .CLOCK_DIVIDER(CD),
        .QUEUE_SIZE   (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .queue_size    (queue_size),
        .dequeue       (dequeue),
        .sample_in     (sample_in),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata         (sdata),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] q[$];
    logic [31:0] exp_q[$];
    int          deq_total = 0;
    bit          pend_valid = 1'b0;
    logic [15:0] pend_val = '0;
    logic [31:0] last_pair = '0;
    logic [15:0] model_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] qsz();
        return (q.size() > 15) ? 4'd15 : 4'(q.size());
    endfunction

    // One system clock as seen by the upstream queue: pop on dequeue, present the word one cycle later.
    task automatic tick();
        @(negedge clock);
        if (pend_valid) begin
            sample_in  = pend_val;
            pend_valid = 1'b0;
        end
        if (dequeue) begin
            deq_total++;
            pend_val   = (q.size() > 0) ? q.pop_front() : 16'hDEAD;
            pend_valid = 1'b1;
        end
        queue_size = qsz();
    endtask

    // Reference rule for one frame: a pair if two samples wait, otherwise an underrun.
    task automatic frame_eval(output bit uf);
        logic [31:0] pair;
        if (q.size() >= 2) begin
            pair      = {q[0], q[1]};
            last_pair = pair;
            uf        = 1'b0;
        end else begin
            uf          = 1'b1;
            model_count = (model_count == 16'hFFFF) ? model_count : model_count + 16'd1;
`ifdef I2S_HOLD_LAST_ON_UNDERRUN_EN
            pair = last_pair;
`else
            pair = 32'h0;
`endif
        end
        exp_q.push_back(pair);
    endtask

    task automatic frame_head();
        int d0;
        bit uf;
        d0 = deq_total;
        frame_eval(uf);
        check("underrun_pulse", underrun, uf);
        tick();
        check("underrun_one_cycle", underrun, 0);
        check("underrun_count", underrun_count, model_count);
        repeat (127) tick();
        check("dequeue_count", deq_total - d0, uf ? 0 : 2);
    endtask

    task automatic frame_tail();
        repeat (128) tick();
    endtask

    task automatic random_refill(input int n, input bit clear);
        if (clear || q.size() > 8)
            q.delete();
        for (int i = 0; i < n; i++)
            q.push_back(16'($urandom));
        queue_size = qsz();
    endtask

    task automatic reset_checks();
        check("rst_bclk", bclk, 0);
        check("rst_lrclk", lrclk, 1);
        check("rst_sdata", sdata, 0);
        check("rst_dequeue", dequeue, 0);
        check("rst_underrun", underrun, 0);
        check("rst_underrun_count", underrun_count, 0);
    endtask

    // Monitor: frame bits are captured on bclk rising edges and compared against the scoreboard queue.
    int          rise_n = 0;
    int          mcyc = 0;
    int          last_rise_cyc = 0;
    int          mslot;
    bit          prev_bclk = 1'b0;
    bit          collecting = 1'b0;
    logic [31:0] word = '0;

    always @(negedge clock) begin
        mcyc++;
        if (!reset) begin
            rise_n     = 0;
            collecting = 1'b0;
            prev_bclk  = 1'b0;
            word       = '0;
        end else begin
            if (bclk && !prev_bclk) begin
                mslot = (31 + rise_n) % 32;
                if (rise_n > 0)
                    check("bclk_period", mcyc - last_rise_cyc, 2 * CD);
                last_rise_cyc = mcyc;
                check("lrclk_slot", lrclk, (mslot >= 16) ? 1 : 0);
                if (mslot == 1) begin
                    collecting = 1'b1;
                    word       = '0;
                end
                word = {word[30:0], sdata};
                if (mslot == 0 && collecting) begin
                    check("exp_queue_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
                    if (exp_q.size() != 0)
                        check("frame_data", word, exp_q.pop_front());
                end
                rise_n++;
            end
            prev_bclk = bclk;
        end
    end

    initial begin
        bit uf;
        int d0;

        q = '{16'hA5C3, 16'h3C5A, 16'h1111, 16'h2222};
        queue_size = qsz();
        repeat (3) @(negedge clock);
        reset_checks();
        reset = 1'b1;
        repeat (8) tick();

        // Frame 0: four queued, first pair A5C3/3C5A.
        frame_head();
        q.delete();
        q.push_back(16'h5555);
        queue_size = qsz();
        frame_tail();

        // Frame 1: a single leftover sample must stay queued.
        frame_head();
        q.delete();
        q.push_back(16'h1234);
        q.push_back(16'h8001);
        queue_size = qsz();
        frame_tail();

        // Frame 2 sends 1234/8001, frame 3 underruns with an empty queue.
        frame_head();
        q.delete();
        queue_size = qsz();
        frame_tail();
        frame_head();
        random_refill($urandom_range(0, 4), 1'b1);
        frame_tail();

        for (int f = 0; f < 10; f++) begin
            frame_head();
            random_refill($urandom_range(0, 4), $urandom_range(0, 1) == 1);
            frame_tail();
        end

        // Saturation: preset the total just below the ceiling, then underrun three times.
        frame_head();
        force dut.underrun_count = 16'hFFFD;
        #1;
        release dut.underrun_count;
        model_count = 16'hFFFD;
        q.delete();
        queue_size = qsz();
        frame_tail();
        for (int f = 0; f < 3; f++) begin
            frame_head();
            if (f == 2)
                random_refill(3, 1'b1);
            frame_tail();
        end

        // Reset between POP_L and POP_R aborts the fetch after one pop.
        d0 = deq_total;
        frame_eval(uf);
        check("abort_frame_no_underrun", underrun, uf);
        tick();
        check("dequeue_in_pop_l", dequeue, 1);
        reset = 1'b0;
        #1;
        reset_checks();
        exp_q.delete();
        repeat (6) tick();
        check("abort_dequeue_total", deq_total - d0, 1);
        reset_checks();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
